// File: rtl/gcd_pkg.sv
// Shared types for the GCD equivalence checker: controller states and the
// step-engine variants that the miter pits against each other.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } gcdState_e;

  // Engine variants: plain subtract-only versus subtract-with-swap
  localparam logic MODE_SUB  = 1'b0;
  localparam logic MODE_SWAP = 1'b1;

  // An engine is finished once either operand is zero or both are equal
  function automatic logic isTerminal(input logic zeroA, input logic zeroB,
                                      input logic equalAB);
    return zeroA || zeroB || equalAB;
  endfunction

endpackage

// File: rtl/gcd_step_engine.sv
// One GCD datapath that takes a single step per enabled clock and then
// freezes its operands, result and step counter once it has finished.
module gcd_step_engine
  import gcd_pkg::*;
#(
  parameter int   W     = 8,
  parameter int   CNT_W = W + 2,
  parameter logic MODE  = MODE_SUB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic [W-1:0]     res_o,
  output logic             fin_o,
  output logic [CNT_W-1:0] cycles_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     res_q, res_d;
  logic             fin_q, fin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The terminating step still counts, so the counter moves before the
  // operand comparison decides whether this is the last step.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    fin_d = fin_q;
    cnt_d = cnt_q;
    if (load_i) begin
      a_d   = a_i;
      b_d   = b_i;
      res_d = '0;
      fin_d = 1'b0;
      cnt_d = '0;
    end else if (step_i && !fin_q) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_ONE;
      end
      if (isTerminal(a_q == '0, b_q == '0, a_q == b_q)) begin
        res_d = (a_q == '0 || b_q == '0) ? (a_q | b_q) : a_q;
        fin_d = 1'b1;
      end else if (a_q > b_q) begin
        a_d = a_q - b_q;
      end else if (MODE == MODE_SWAP) begin
        a_d = b_q;
        b_d = a_q;
      end else begin
        b_d = b_q - a_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      fin_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      fin_q <= fin_d;
      cnt_q <= cnt_d;
    end
  end

  assign res_o    = res_q;
  assign fin_o    = fin_q;
  assign cycles_o = cnt_q;

endmodule

// File: rtl/gcd_equiv_checker.sv
// Lockstep miter of a subtract-only and a subtract-with-swap GCD engine.
// Define GCD_TIMEOUT_EN to bound each run to TMO_CYCLES cycles in RUN.
module gcd_equiv_checker
  import gcd_pkg::*;
#(
  parameter int W          = 8,
  parameter int CNT_W      = W + 2,
  parameter int TMO_CYCLES = 2 * (2 ** W) + 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     a_in,
  input  logic [W-1:0]     b_in,
  output logic             ready,
  output logic             done,
  output logic [W-1:0]     result,
  output logic [CNT_W-1:0] fast_cycles,
  output logic [CNT_W-1:0] slow_cycles,
  output logic             nequiv,
  output logic             nequiv_sticky,
  output logic             timeout
);

  gcdState_e    state_q;
  logic         ready_q;
  logic         done_q;
  logic [W-1:0] result_q;
  logic         nequiv_q;
  logic         nequivSticky_q;

  logic             acceptStart;
  logic             engineStep;
  logic [W-1:0]     resFast;
  logic [W-1:0]     resSlow;
  logic             finFast;
  logic             finSlow;
  logic [CNT_W-1:0] cyclesFast;
  logic [CNT_W-1:0] cyclesSlow;

  assign acceptStart = start && (state_q == IDLE || state_q == DONE);
  assign engineStep  = (state_q == RUN);

  gcd_step_engine #(
    .W     (W),
    .CNT_W (CNT_W),
    .MODE  (MODE_SUB)
  ) u_engFast (
    .clk      (clk),
    .reset    (reset),
    .load_i   (acceptStart),
    .step_i   (engineStep),
    .a_i      (a_in),
    .b_i      (b_in),
    .res_o    (resFast),
    .fin_o    (finFast),
    .cycles_o (cyclesFast)
  );

  gcd_step_engine #(
    .W     (W),
    .CNT_W (CNT_W),
    .MODE  (MODE_SWAP)
  ) u_engSlow (
    .clk      (clk),
    .reset    (reset),
    .load_i   (acceptStart),
    .step_i   (engineStep),
    .a_i      (a_in),
    .b_i      (b_in),
    .res_o    (resSlow),
    .fin_o    (finSlow),
    .cycles_o (cyclesSlow)
  );

`ifdef GCD_TIMEOUT_EN
  localparam int RUN_W = $clog2(TMO_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(TMO_CYCLES);

  logic [RUN_W-1:0] runCnt_q;
  logic             timeout_q;

  // A genuine finish takes precedence over a timeout landing on the same cycle;
  // a timed-out run never reports or latches a mismatch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ready_q        <= 1'b1;
      done_q         <= 1'b0;
      result_q       <= '0;
      nequiv_q       <= 1'b0;
      nequivSticky_q <= 1'b0;
      runCnt_q       <= '0;
      timeout_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= RUN;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            nequiv_q  <= 1'b0;
            runCnt_q  <= '0;
            timeout_q <= 1'b0;
          end
        end
        RUN: begin
          runCnt_q <= runCnt_q + RUN_ONE;
          if (finFast && finSlow) begin
            state_q <= CMP;
          end else if (runCnt_q == RUN_LIMIT) begin
            state_q   <= CMP;
            timeout_q <= 1'b1;
          end
        end
        CMP: begin
          state_q  <= DONE;
          ready_q  <= 1'b1;
          done_q   <= 1'b1;
          result_q <= resFast;
          if (!timeout_q) begin
            nequiv_q <= (resFast != resSlow);
            if (resFast != resSlow) begin
              nequivSticky_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  // Controller with registered handshake and compare outputs; engines are
  // loaded on the accepting edge and step only while the state is RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ready_q        <= 1'b1;
      done_q         <= 1'b0;
      result_q       <= '0;
      nequiv_q       <= 1'b0;
      nequivSticky_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q  <= RUN;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            nequiv_q <= 1'b0;
          end
        end
        RUN: begin
          if (finFast && finSlow) begin
            state_q <= CMP;
          end
        end
        CMP: begin
          state_q  <= DONE;
          ready_q  <= 1'b1;
          done_q   <= 1'b1;
          result_q <= resFast;
          nequiv_q <= (resFast != resSlow);
          if (resFast != resSlow) begin
            nequivSticky_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign ready         = ready_q;
  assign done          = done_q;
  assign result        = result_q;
  assign nequiv        = nequiv_q;
  assign nequiv_sticky = nequivSticky_q;
  assign fast_cycles   = cyclesFast;
  assign slow_cycles   = cyclesSlow;

endmodule

// File: tb/tb_gcd_equiv_checker.sv
// Self-checking bench for gcd_equiv_checker (default build, W=8): directed
// scenarios plus random operands against a Euclid-based reference model.
module tb_gcd_equiv_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic [9:0] fast_cycles;
  logic [9:0] slow_cycles;
  logic       nequiv;
  logic       nequiv_sticky;
  logic       timeout;

  int checkCount = 0;
  int failCount  = 0;

  gcd_equiv_checker #(.W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .a_in          (a_in),
    .b_in          (b_in),
    .ready         (ready),
    .done          (done),
    .result        (result),
    .fast_cycles   (fast_cycles),
    .slow_cycles   (slow_cycles),
    .nequiv        (nequiv),
    .nequiv_sticky (nequiv_sticky),
    .timeout       (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference GCD by the modulo form of Euclid, with gcd(x,0)=x
  function automatic int refGcd(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Number of steps an engine takes, counting the terminating step
  function automatic int refSteps(input int a, input int b, input bit swap);
    int x = a;
    int y = b;
    int t;
    int n = 1;
    while (!(x == 0 || y == 0 || x == y)) begin
      if (x > y) x = x - y;
      else if (swap) begin
        t = x; x = y; y = t;
      end else y = y - x;
      n++;
    end
    return n;
  endfunction

  // Launch one run and count edges after the accepting edge until done rises
  task automatic runOp(input logic [7:0] a, input logic [7:0] b, input string tag,
                       output int edges, output bit ok);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < 2000) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checkCount++;
      failCount++;
      $display("[TB] FAIL %s_done_wait: done=%b after %0d edges, required 1", tag, done, edges);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checkCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b want 1", ready); end
    checkCount++; if (done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checkCount++; if (result !== 8'd0) begin failCount++; $display("[TB] FAIL reset_result: got %0d want 0", result); end
    checkCount++; if (fast_cycles !== 10'd0) begin failCount++; $display("[TB] FAIL reset_fast: got %0d want 0", fast_cycles); end
    checkCount++; if (slow_cycles !== 10'd0) begin failCount++; $display("[TB] FAIL reset_slow: got %0d want 0", slow_cycles); end
    checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL reset_nequiv: got %b want 0", nequiv); end
    checkCount++; if (nequiv_sticky !== 1'b0) begin failCount++; $display("[TB] FAIL reset_sticky: got %b want 0", nequiv_sticky); end
    checkCount++; if (timeout !== 1'b0) begin failCount++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout); end
  endtask

  task automatic test_basic();
    int edges;
    bit ok;
    runOp(8'd12, 8'd18, "basic", edges, ok);
    if (ok) begin
      checkCount++; if (result !== 8'd6) begin failCount++; $display("[TB] FAIL basic_result: got %0d want 6", result); end
      checkCount++; if (fast_cycles !== 10'd3) begin failCount++; $display("[TB] FAIL basic_fast: got %0d want 3", fast_cycles); end
      checkCount++; if (slow_cycles !== 10'd5) begin failCount++; $display("[TB] FAIL basic_slow: got %0d want 5", slow_cycles); end
      checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL basic_nequiv: got %b want 0", nequiv); end
      checkCount++; if (edges !== 7) begin failCount++; $display("[TB] FAIL basic_latency: got %0d edges want 7", edges); end
      checkCount++; if (ready !== 1'b1) begin failCount++; $display("[TB] FAIL basic_ready: got %b want 1", ready); end
    end
  endtask

  task automatic test_zero_operands();
    int edges;
    bit ok;
    runOp(8'd0, 8'd5, "zero5", edges, ok);
    if (ok) begin
      checkCount++; if (result !== 8'd5) begin failCount++; $display("[TB] FAIL zero5_result: got %0d want 5", result); end
      checkCount++; if (fast_cycles !== 10'd1 || slow_cycles !== 10'd1) begin failCount++; $display("[TB] FAIL zero5_cycles: got %0d/%0d want 1/1", fast_cycles, slow_cycles); end
      checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL zero5_nequiv: got %b want 0", nequiv); end
    end
    runOp(8'd0, 8'd0, "zero0", edges, ok);
    if (ok) begin
      checkCount++; if (result !== 8'd0) begin failCount++; $display("[TB] FAIL zero0_result: got %0d want 0", result); end
      checkCount++; if (fast_cycles !== 10'd1 || slow_cycles !== 10'd1) begin failCount++; $display("[TB] FAIL zero0_cycles: got %0d/%0d want 1/1", fast_cycles, slow_cycles); end
      checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL zero0_nequiv: got %b want 0", nequiv); end
      checkCount++; if (edges !== 3) begin failCount++; $display("[TB] FAIL zero0_latency: got %0d edges want 3", edges); end
    end
  endtask

  task automatic test_ignore_start();
    int edges;
    bit ok;
    @(negedge clk);
    a_in  = 8'd7;
    b_in  = 8'd7;
    start = 1'b1;
    @(posedge clk);
    // Present a second request while the block is in RUN
    @(negedge clk);
    checkCount++; if (done !== 1'b0 || ready !== 1'b0) begin failCount++; $display("[TB] FAIL ign_busy: got done=%b ready=%b want 0/0", done, ready); end
    a_in = 8'd9;
    b_in = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    ok    = 1'b0;
    while (!ok && edges < 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (done === 1'b1) ok = 1'b1;
    end
    checkCount++; if (!ok) begin failCount++; $display("[TB] FAIL ign_done_wait: done=%b want 1", done); end
    if (ok) begin
      checkCount++; if (result !== 8'd7) begin failCount++; $display("[TB] FAIL ign_result: got %0d want 7", result); end
    end
    runOp(8'd9, 8'd3, "restart", edges, ok);
    if (ok) begin
      checkCount++; if (result !== 8'd3) begin failCount++; $display("[TB] FAIL restart_result: got %0d want 3", result); end
    end
  endtask

  task automatic test_mismatch();
    int edges;
    bit ok;
    force dut.resSlow = 8'd2;
    runOp(8'd12, 8'd18, "forced", edges, ok);
    if (ok) begin
      checkCount++; if (nequiv !== 1'b1) begin failCount++; $display("[TB] FAIL forced_nequiv: got %b want 1", nequiv); end
      checkCount++; if (nequiv_sticky !== 1'b1) begin failCount++; $display("[TB] FAIL forced_sticky: got %b want 1", nequiv_sticky); end
      checkCount++; if (result !== 8'd6) begin failCount++; $display("[TB] FAIL forced_result: got %0d want 6", result); end
    end
    release dut.resSlow;
    runOp(8'd12, 8'd18, "clean", edges, ok);
    if (ok) begin
      checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL clean_nequiv: got %b want 0", nequiv); end
      checkCount++; if (nequiv_sticky !== 1'b1) begin failCount++; $display("[TB] FAIL clean_sticky: got %b want 1", nequiv_sticky); end
    end
    doReset();
    checkCount++; if (nequiv_sticky !== 1'b0) begin failCount++; $display("[TB] FAIL reset_clears_sticky: got %b want 0", nequiv_sticky); end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    a_in  = 8'd255;
    b_in  = 8'd1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkCount++; if (fast_cycles !== 10'd2) begin failCount++; $display("[TB] FAIL midrun_progress: got %0d want 2", fast_cycles); end
    doReset();
    checkCount++; if (ready !== 1'b1 || done !== 1'b0) begin failCount++; $display("[TB] FAIL midrun_abort: got ready=%b done=%b want 1/0", ready, done); end
    checkCount++; if (fast_cycles !== 10'd0 || slow_cycles !== 10'd0) begin failCount++; $display("[TB] FAIL midrun_counters: got %0d/%0d want 0/0", fast_cycles, slow_cycles); end
    // Reset must win over a simultaneous start
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a_in  = 8'd12;
    b_in  = 8'd18;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkCount++; if (ready !== 1'b1 || done !== 1'b0 || fast_cycles !== 10'd0) begin failCount++; $display("[TB] FAIL reset_start: got ready=%b done=%b fast=%0d want 1/0/0", ready, done, fast_cycles); end
  endtask

  task automatic test_long_run();
    int edges;
    bit ok;
    runOp(8'd255, 8'd1, "long", edges, ok);
    if (ok) begin
      checkCount++; if (result !== 8'd1) begin failCount++; $display("[TB] FAIL long_result: got %0d want 1", result); end
      checkCount++; if (fast_cycles !== 10'd255) begin failCount++; $display("[TB] FAIL long_fast: got %0d want 255", fast_cycles); end
      checkCount++; if (timeout !== 1'b0) begin failCount++; $display("[TB] FAIL long_timeout: got %b want 0", timeout); end
    end
  endtask

  task automatic test_random();
    int edges;
    bit ok;
    int a;
    int b;
    int expF;
    int expS;
    int expG;
    for (int i = 0; i < 24; i++) begin
      a = (i % 6 == 0) ? 0 : int'($urandom_range(1, 255));
      b = (i % 7 == 3) ? a : int'($urandom_range(0, 255));
      expG = refGcd(a, b);
      expF = refSteps(a, b, 1'b0);
      expS = refSteps(a, b, 1'b1);
      runOp(8'(a), 8'(b), "rand", edges, ok);
      if (ok) begin
        checkCount++; if (result !== 8'(expG)) begin failCount++; $display("[TB] FAIL rand_result(%0d,%0d): got %0d want %0d", a, b, result, expG); end
        checkCount++; if (fast_cycles !== 10'(expF)) begin failCount++; $display("[TB] FAIL rand_fast(%0d,%0d): got %0d want %0d", a, b, fast_cycles, expF); end
        checkCount++; if (slow_cycles !== 10'(expS)) begin failCount++; $display("[TB] FAIL rand_slow(%0d,%0d): got %0d want %0d", a, b, slow_cycles, expS); end
        checkCount++; if (nequiv !== 1'b0) begin failCount++; $display("[TB] FAIL rand_nequiv(%0d,%0d): got %b want 0", a, b, nequiv); end
        checkCount++; if (edges !== ((expF > expS ? expF : expS) + 2)) begin failCount++; $display("[TB] FAIL rand_latency(%0d,%0d): got %0d want %0d", a, b, edges, (expF > expS ? expF : expS) + 2); end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a_in  = 8'd0;
    b_in  = 8'd0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_zero_operands();
    test_ignore_start();
    test_mismatch();
    test_reset_mid_run();
    test_long_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
